x_uart_rx: RTL and testbench
============================

Name: x_uart_rx

Overview:
UART 8N1 receiver. It is the receive-side counterpart of x_uart_tx and uses the same bit timing and the same valid/accept byte interface. It samples the asynchronous serial line at mid-bit, assembles bytes LSB-first and presents them on a held valid/accept handshake. It also flags framing and overrun errors. It sits at the board-facing edge of the delay-line control path, feeding command bytes into the core.

Parameters:
CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200). Must be >= 4.
HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit detection to the start-bit mid-sample (derived, localparam).

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-low reset
i_rx  input  1  asynchronous serial line, idles high
o_data  output  8  received byte, valid while o_valid=1
o_valid  output  1  byte available; held until accepted
i_accept  input  1  consumer takes the byte when o_valid & i_accept
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: byte completed while previous byte unaccepted

Behaviour:
- Reset (i_rst=0 at a clock edge) applies these values:
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
  - Both synchronizer flops = 1.
  - State = IDLE; bit counter, bit index and shift register = 0.
- Reset mid-frame abandons the partial byte. No error pulse is produced.
- Synchronizer: 2 flops on i_rx. The FSM sees only the synced value rx_s, which lags i_rx by 2 cycles.
- Baud counter: width $clog2(CLKS_PER_BIT). It is cleared on every state entry and counts up by 1 each cycle.
- IDLE: if rx_s=0, go to START.
- START: when counter = HALF_BIT-1, sample rx_s.
  - Sample 0: go to DATA, index = 0.
  - Sample 1: treat as a glitch and go to IDLE. No outputs change.
- DATA: when counter = CLKS_PER_BIT-1, sample rx_s into shift[index] (LSB first) and clear the counter.
  - After index 7 is sampled, go to STOP.
- STOP: when counter = CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: deliver the byte (see handshake rules), go to IDLE.
  - Sample 0: pulse o_frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition being read as repeated 0x00 bytes.
- Delivery, registered, taking effect the cycle after the stop sample:
  - o_valid=0, or o_valid=1 with i_accept=1 in the same cycle: o_data takes the new byte and o_valid becomes 1.
  - o_valid=1 with i_accept=0: o_data and o_valid are unchanged, the new byte is dropped, o_overrun pulses for 1 cycle.
- Handshake: o_valid & i_accept with no simultaneous delivery clears o_valid on the next cycle. o_data holds its last value.
- i_accept is ignored while o_valid=0.
- Latency: o_valid rises at cycle 3 + HALF_BIT + 9*CLKS_PER_BIT after the i_rx falling edge.
- The stop-bit sample ends the frame, so a back-to-back start bit is detected without loss.

Decomposition:
- Package x_uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - UART_DATA_W = 8.
  - Default CLKS_PER_BIT, shared with x_uart_tx.
- One sub-module, x_sync: a 2-flop synchronizer with a reset-value parameter. It is reused by other asynchronous inputs.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
1. Send 0xA5 as an 8N1 frame, i_accept=0 -> o_valid rises exactly 155 cycles after the falling edge with o_data=0xA5 and stays high; assert i_accept for 1 cycle -> o_valid=0 on the next cycle.
2. Drive i_rx low for 4 cycles, then high -> no o_valid, no o_frame_err, FSM back in IDLE; a following 0x3C frame is received correctly.
3. Send 0x81 with the stop bit driven low, holding the line low for 40 more cycles -> single o_frame_err pulse, no o_valid, no bytes during the low period; after the line goes high, 0x3C is received correctly.
4. Send 0x01 then 0xFF back-to-back with i_accept=0 -> o_data stays 0x01, o_overrun pulses once at the 0xFF stop sample, o_valid stays 1.
5. Hold i_accept=1 continuously and send 0x12 then 0x34 back-to-back -> each byte is seen for 1 cycle with o_valid=1, no o_overrun; also hit delivery in the same cycle as accept -> o_data=0x34, o_valid stays 1.
6. Pull i_rst low mid-way through the DATA bits of 0xF0 -> all outputs are 0 the next cycle; after release, 0x55 is received correctly with no error pulses.

Source files
------------

// File: rtl/x_uart_pkg.sv
// rtl/x_uart_pkg.sv - shared UART types and constants
//
// Shared by the UART receiver and transmitter:
//   rx_state_t         receiver FSM states
//   UART_DATA_W        payload width of one 8N1 character
//   UART_CLKS_PER_BIT  default bit period in clock cycles (100 MHz / 115200)

package x_uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/x_uart_rx_if.sv
// rtl/x_uart_rx_if.sv - received-byte handshake and error flags
//
// Signals:
//   o_data       received byte, meaningful while o_valid=1
//   o_valid      byte available, held until accepted
//   i_accept     consumer takes the byte when o_valid & i_accept
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_overrun    one-cycle pulse, byte completed while previous unaccepted
// Modports:
//   master  receiver side (drives data/valid/errors)
//   slave   consumer side (drives accept)

interface x_uart_rx_if import x_uart_pkg::*; ();

  logic [UART_DATA_W-1:0] o_data;
  logic                   o_valid;
  logic                   i_accept;
  logic                   o_frame_err;
  logic                   o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_accept
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_accept
  );

endinterface

// File: rtl/x_sync.sv
// rtl/x_sync.sv - two-flop synchronizer for an asynchronous input
//
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-low reset, both flops load RESET_VAL
//   i_d    asynchronous input
//   o_q    synchronized output, lags i_d by two cycles
// Parameters:
//   RESET_VAL  value held by both flops in reset (idle level of the line)

module x_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/x_uart_rx.sv
// rtl/x_uart_rx.sv - UART 8N1 receiver with held valid/accept output
//
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-low reset
//   i_rx    asynchronous serial line, idles high
//   rx_if   master side of x_uart_rx_if (byte handshake, error pulses)
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit, must be >= 4

module x_uart_rx import x_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  x_uart_rx_if.master rx_if
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic deliver;
  logic take;

  x_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  // Consumer handshake only counts while a byte is actually on offer.
  assign take = valid_q & rx_if.i_accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    if (take) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Mid-start-bit recheck filters short glitches on the line.
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        // Leaving at the stop-bit centre gives half a bit of slack to
        // catch a back-to-back start edge.
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new frame.
        if (rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A byte completing in the same cycle as an accept replaces the old one.
    if (deliver) begin
      if (!valid_q || take) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_overrun   = ovr_q;

endmodule

// File: tb/tb_x_uart_rx.sv
// tb/tb_x_uart_rx.sv - self-checking bench for x_uart_rx

module tb_x_uart_rx;
  import x_uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  x_uart_rx_if rx_if ();

  x_uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_rx  (rx),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Event monitor, updated just after each rising edge.
  int   cyc       = 0;
  int   rise_cnt  = 0;
  int   last_rise = -1;
  int   valid_cyc = 0;
  int   ferr_cnt  = 0;
  int   ovr_cnt   = 0;
  int   last_ovr  = -1;
  logic prev_valid = 1'b0;
  logic [7:0] seen_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_if.o_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt++;
      last_rise = cyc;
    end
    if (rx_if.o_valid === 1'b1) begin
      valid_cyc++;
      seen_q.push_back(rx_if.o_data);
    end
    if (rx_if.o_frame_err === 1'b1) ferr_cnt++;
    if (rx_if.o_overrun === 1'b1) begin
      ovr_cnt++;
      last_ovr = cyc;
    end
    prev_valid = rx_if.o_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one 8N1 character: start, 8 data bits LSB first, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic do_accept();
    rx_if.i_accept = 1'b1;
    @(negedge clk);
    rx_if.i_accept = 1'b0;
  endtask

  // Sends one byte, expects delivery LAT cycles after the start edge, accepts it.
  task automatic rx_byte(input string tag, input logic [7:0] b);
    int t0;
    int r0;
    t0 = cyc;
    r0 = rise_cnt;
    send_frame(b, 1'b1);
    chk({tag, "_lat"}, last_rise, t0 + LAT);
    chk({tag, "_rise"}, rise_cnt - r0, 1);
    chk({tag, "_data"}, rx_if.o_data, b);
    chk({tag, "_valid"}, rx_if.o_valid, 1);
    do_accept();
  endtask

  initial begin
    int t0, t1, r0, f0, o0, v0, mode, gap;
    logic [7:0] b0, b1;
    logic [7:0] exp_q[$];

    rx_if.i_accept = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_if.o_valid, 0);
    chk("rst_data", rx_if.o_data, 0);
    chk("rst_ferr", rx_if.o_frame_err, 0);
    chk("rst_ovr", rx_if.o_overrun, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_sync", dut.rx_s, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0xA5, held until accepted.
    t0 = cyc;
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b1);
    chk("t1_lat", last_rise, t0 + LAT);
    chk("t1_data", rx_if.o_data, 8'hA5);
    repeat (10) @(negedge clk);
    chk("t1_held", rx_if.o_valid, 1);
    chk("t1_rise", rise_cnt - r0, 1);
    do_accept();
    chk("t1_cleared", rx_if.o_valid, 0);
    chk("t1_data_hold", rx_if.o_data, 8'hA5);

    // 2: short low glitch rejected.
    r0 = rise_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_no_valid", rise_cnt - r0, 0);
    chk("t2_no_ferr", ferr_cnt - f0, 0);
    chk("t2_idle", 32'(dut.state_q), 32'(IDLE));
    rx_byte("t2_3c", 8'h3C);

    // 3: framing error with a long break.
    r0 = rise_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3_ferr", ferr_cnt - f0, 1);
    chk("t3_no_valid", rise_cnt - r0, 0);
    chk("t3_wait", 32'(dut.state_q), 32'(WAIT_IDLE));
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_idle", 32'(dut.state_q), 32'(IDLE));
    rx_byte("t3_3c", 8'h3C);

    // 4: overrun, second byte dropped.
    r0 = rise_cnt;
    o0 = ovr_cnt;
    send_frame(8'h01, 1'b1);
    t1 = cyc;
    send_frame(8'hFF, 1'b1);
    chk("t4_data", rx_if.o_data, 8'h01);
    chk("t4_valid", rx_if.o_valid, 1);
    chk("t4_ovr", ovr_cnt - o0, 1);
    chk("t4_ovr_time", last_ovr, t1 + LAT);
    chk("t4_rise", rise_cnt - r0, 1);
    do_accept();

    // 5a: continuous accept, back-to-back bytes.
    o0 = ovr_cnt;
    v0 = valid_cyc;
    seen_q.delete();
    rx_if.i_accept = 1'b1;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (5) @(negedge clk);
    rx_if.i_accept = 1'b0;
    chk("t5_vcyc", valid_cyc - v0, 2);
    chk("t5_nseen", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("t5_b0", seen_q[0], 8'h12);
      chk("t5_b1", seen_q[1], 8'h34);
    end
    chk("t5_no_ovr", ovr_cnt - o0, 0);

    // 5b: accept coincides with the next delivery.
    o0 = ovr_cnt;
    r0 = rise_cnt;
    send_frame(8'h12, 1'b1);
    t1 = cyc;
    fork
      send_frame(8'h34, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_if.i_accept = 1'b1;
        @(negedge clk);
        rx_if.i_accept = 1'b0;
      end
    join
    chk("t5b_data", rx_if.o_data, 8'h34);
    chk("t5b_valid", rx_if.o_valid, 1);
    chk("t5b_no_ovr", ovr_cnt - o0, 0);
    chk("t5b_rise", rise_cnt - r0, 1);

    // 6: reset in the middle of 0xF0 data bits (0x34 still held).
    rx = 1'b0;
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    chk("t6_in_data", 32'(dut.state_q), 32'(DATA));
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    chk("t6_valid", rx_if.o_valid, 0);
    chk("t6_data", rx_if.o_data, 0);
    chk("t6_ferr", rx_if.o_frame_err, 0);
    chk("t6_ovr", rx_if.o_overrun, 0);
    rst_n = 1'b1;
    r0 = rise_cnt;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    repeat (20) @(negedge clk);
    chk("t6_quiet", rise_cnt - r0, 0);
    rx_byte("t6_55", 8'h55);
    chk("t6_no_ferr", ferr_cnt - f0, 0);
    chk("t6_no_ovr", ovr_cnt - o0, 0);

    // Random traffic against a queue model of the handshake rules.
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(0, 20);
      b0   = 8'($urandom);
      b1   = 8'($urandom);
      repeat (gap) @(negedge clk);
      o0 = ovr_cnt;
      exp_q.delete();
      seen_q.delete();
      if (mode == 0) begin
        exp_q.push_back(b0);
        rx_byte("rnd_single", b0);
      end else if (mode == 1) begin
        // Unaccepted first byte stays visible; second byte is lost.
        exp_q.push_back(b0);
        send_frame(b0, 1'b1);
        send_frame(b1, 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("rnd_ovr_data", rx_if.o_data, exp_q[0]);
        chk("rnd_ovr_cnt", ovr_cnt - o0, 1);
        do_accept();
      end else begin
        // Always-ready consumer sees every byte exactly once.
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        rx_if.i_accept = 1'b1;
        send_frame(b0, 1'b1);
        send_frame(b1, 1'b1);
        repeat (3) @(negedge clk);
        rx_if.i_accept = 1'b0;
        chk("rnd_stream_n", seen_q.size(), exp_q.size());
        if (seen_q.size() == 2) begin
          chk("rnd_stream_b0", seen_q[0], exp_q[0]);
          chk("rnd_stream_b1", seen_q[1], exp_q[1]);
        end
        chk("rnd_stream_ovr", ovr_cnt - o0, 0);
      end
      chk("rnd_idle_valid", rx_if.o_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
